// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch: PC, imem req/gnt/rvalid, instruction FIFO, redirect flush
// Optional feature macro: FETCH_NOP_BUBBLE_EN (inst_o reads as addi x0,x0,0 while no instruction is valid)
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pq_rd;
  logic [AW-1:0] pq_wr;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   pcq       [FIFO_DEPTH];

  logic          active;
  logic          redirect_eff;
  logic          rvalid_eff;
  logic          pop_raw;
  logic          pop;
  logic          push;
  logic          req;
  logic          grant;
  logic [UW-1:0] used;
  logic [CW-1:0] remain;
  logic [CW-1:0] count_next;
  logic [CW-1:0] drop_redirect;
  logic [AW-1:0] rd_next;
  logic [31:0]   resp_pc;
  logic [31:0]   head_inst;
  logic [31:0]   head_pc;

  // Credit check, handshakes and the FIFO head that will be presented next cycle
  always_comb begin
    active        = (state != BOOT);
    redirect_eff  = redirect_i & active;
    rvalid_eff    = imem_rvalid_i & (outstanding != '0);
    pop_raw       = inst_valid_o & inst_ready_i;
    // A pop this cycle frees its slot, so streaming at ready=1 never bubbles
    used          = UW'(fifo_count) + UW'(outstanding) - UW'(pop_raw);
    req           = active & ~redirect_i & (used < UW'(FIFO_DEPTH));
    grant         = req & imem_gnt_i;
    pop           = pop_raw & ~redirect_eff;
    push          = rvalid_eff & (drop == '0) & ~redirect_eff;
    drop_redirect = outstanding + CW'(grant) - CW'(rvalid_eff);
    resp_pc       = pcq[pq_rd];
    rd_next       = rd_ptr + AW'(pop);
    remain        = fifo_count - CW'(pop);
    count_next    = redirect_eff ? '0 : remain + CW'(push);
    if (remain == '0) begin
      head_inst = imem_rdata_i;
      head_pc   = resp_pc;
    end else begin
      head_inst = fifo_inst[rd_next];
      head_pc   = fifo_pc[rd_next];
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc;

  // Fetch state machine: one boot cycle, then RUN, FLUSH while stale responses remain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= BOOT;
      drop  <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN, FLUSH: begin
          if (redirect_eff) begin
            drop  <= drop_redirect;
            state <= (drop_redirect != '0) ? FLUSH : RUN;
          end else if (rvalid_eff && (drop != '0)) begin
            drop <= drop - 1'b1;
            if (drop == CW'(1)) state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  // Fetch PC, in-flight counter and FIFO / PC-queue pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rvalid_eff);
      fifo_count  <= count_next;
      if (grant)      pq_wr <= pq_wr + 1'b1;
      if (rvalid_eff) pq_rd <= pq_rd + 1'b1;
      if (redirect_eff) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
      end
      if (redirect_eff)  fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
      else if (grant)    fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters above
  always_ff @(posedge clk_i) begin
    if (grant) pcq[pq_wr] <= fetch_pc;
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata_i;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

  // Registered instruction output stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_valid_o <= 1'b0;
`ifdef FETCH_NOP_BUBBLE_EN
      inst_o       <= NOP;
`else
      inst_o       <= 32'h0;
`endif
      pc_o         <= 32'h0;
    end else begin
      inst_valid_o <= (count_next != '0);
      if (count_next != '0) begin
        inst_o <= head_inst;
        pc_o   <= head_pc;
      end else begin
`ifdef FETCH_NOP_BUBBLE_EN
        inst_o <= NOP;
`else
        inst_o <= inst_o;
`endif
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .pc_o(pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int earliest; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } inst_t;

  pend_t       pend[$];
  inst_t       expq[$];
  logic [31:0] model_pc;
  logic [31:0] last_inst;
  logic [31:0] last_pc;
  int          cyc;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction

  task automatic do_reset();
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    inst_ready_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_req", 32'(imem_req_o), 32'h0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", 32'(inst_valid_o), 32'h0);
`ifdef FETCH_NOP_BUBBLE_EN
    check("rst_inst", inst_o, NOP);
`else
    check("rst_inst", inst_o, 32'h0);
`endif
    check("rst_pc", pc_o, 32'h0);
    pend.delete();
    expq.delete();
    model_pc  = 32'h0;
    last_inst = 32'h0;
    last_pc   = 32'h0;
    cyc       = 0;
    rst_i     = 1'b0;
  endtask

  // One clock cycle: drive at posedge+1, check and advance the model at negedge
  task automatic cycle(input bit rdy, input bit gnt, input bit rv_en, input bit redir,
                       input logic [31:0] tgt, input bit spur);
    bit    boot, redir_eff, pop_raw, exp_req, grant, rv;
    inst_t e;
    pend_t p;
    inst_ready_i  = rdy;
    imem_gnt_i    = gnt;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    if (pend.size() > 0) rv = rv_en && (pend[0].earliest <= cyc);
    else                 rv = spur;
    imem_rvalid_i = rv;
    imem_rdata_i  = (pend.size() > 0) ? mem_data(pend[0].addr) : $urandom;
    @(negedge clk_i);
    boot      = (cyc == 0);
    redir_eff = redir && !boot;
    check("inst_valid", 32'(inst_valid_o), 32'(expq.size() != 0));
    if (expq.size() != 0) begin
      check("pc", pc_o, expq[0].pc);
      check("inst", inst_o, expq[0].inst);
      last_pc   = expq[0].pc;
      last_inst = expq[0].inst;
    end else begin
`ifdef FETCH_NOP_BUBBLE_EN
      check("inst_nop", inst_o, NOP);
`else
      check("inst_hold", inst_o, last_inst);
`endif
      check("pc_hold", pc_o, last_pc);
    end
    pop_raw = (expq.size() != 0) && rdy;
    exp_req = !boot && !redir && ((expq.size() + pend.size() - int'(pop_raw)) < DEPTH);
    check("req", 32'(imem_req_o), 32'(exp_req));
    if (imem_req_o) check("addr", imem_addr_o, model_pc);
    grant = imem_req_o && gnt;
    if (pop_raw && !redir_eff) void'(expq.pop_front());
    if (redir_eff) begin
      expq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
    end
    if (rv && (pend.size() > 0)) begin
      p = pend.pop_front();
      if (!p.stale) begin
        e.pc   = p.addr;
        e.inst = mem_data(p.addr);
        expq.push_back(e);
      end
    end
    if (grant) begin
      p.addr     = model_pc;
      p.earliest = cyc + 1;
      p.stale    = 1'b0;
      pend.push_back(p);
      model_pc   = model_pc + 32'd4;
    end
    if (redir_eff) model_pc = tgt & 32'hFFFF_FFFC;
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    do_reset();

    // streaming: gnt=1, rvalid next cycle, ready=1
    repeat (12) cycle(1, 1, 1, 0, 32'h0, 0);
    // backpressure then release
    repeat (6) cycle(0, 1, 1, 0, 32'h0, 0);
    repeat (6) cycle(1, 1, 1, 0, 32'h0, 0);
    // grant withheld: request must stay put
    repeat (5) cycle(1, 0, 1, 0, 32'h0, 0);
    repeat (4) cycle(1, 1, 1, 0, 32'h0, 0);
    // two fetches in flight, then redirect to an unaligned target
    for (int i = 0; i < 20 && pend.size() < 2; i++) cycle(1, 1, 0, 0, 32'h0, 0);
    cycle(1, 1, 0, 1, 32'h0000_0103, 0);
    repeat (10) cycle(1, 1, 1, 0, 32'h0, 0);
    // redirect colliding with a pop and an rvalid while one entry is buffered
    for (int i = 0; i < 20 && !(expq.size() == 1 && pend.size() >= 1); i++)
      cycle(0, 1, expq.size() == 0, 0, 32'h0, 0);
    cycle(1, 0, 1, 1, 32'h0000_0200, 0);
    repeat (8) cycle(1, 1, 1, 0, 32'h0, 0);
    // PC wrap past 0xFFFF_FFFC
    cycle(1, 1, 1, 1, 32'hFFFF_FFF4, 0);
    repeat (12) cycle(1, 1, 1, 0, 32'h0, 0);
    // reset with fetches in flight, then a redirect during boot (ignored)
    repeat (2) cycle(0, 1, 0, 0, 32'h0, 0);
    do_reset();
    cycle(1, 1, 1, 1, 32'h0000_0500, 0);
    repeat (8) cycle(1, 1, 1, 0, 32'h0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            $urandom_range(0, 24) == 0, tgt, $urandom_range(0, 15) == 0);
      if (i == 1500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
